// File: rtl/dbus_lsu_master.sv
// Load/store initiator for the core data bus: single outstanding access,
// read-modify-write for sub-word stores, sign/zero-extended loads, per-phase timeout.
package dbus_lsu_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] w_data;
    logic            w_en;
    logic            req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [XLEN-1:0] r_data;
    logic            ack;
  } type_peri2dbus_s;
endpackage

module dbus_lsu_master
  import dbus_lsu_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE      = 32'h0000_0000,
  parameter logic [31:0] DMEM_BYTES     = 32'h0001_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [1:0]      lsu_size_i,
  input  logic            lsu_unsigned_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_busy_o,
  output logic            lsu_done_o,
  output logic [1:0]      lsu_err_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            dmem_sel_o,
  output type_dbus2peri_s dbus_o,
  input  type_peri2dbus_s dbus_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RESP = 2'd3} state_t;

  state_t            state_r, state_s;
  logic [XLEN-1:0]   addr_r, wdata_r, wr_word_r, rdata_r;
  logic [1:0]        size_r, err_r, acc_err_s;
  logic              we_r, uns_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              timeout_s;
  logic [32:0]       win_end_s;

  // Insert the right-aligned store data into its lane of the read word.
  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] res;
    res = word;
    case (size)
      2'b00:   res[{lane, 3'b000} +: 8]        = wd[7:0];
      2'b01:   res[{lane[1], 4'b0000} +: 16]   = wd[15:0];
      default: res = wd;
    endcase
    return res;
  endfunction

  // Pick the addressed lane and extend it to a full word.
  function automatic logic [31:0] extract_load(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   res = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
  assign win_end_s = {1'b0, DMEM_BASE} + {1'b0, DMEM_BYTES};

  // Request classification: misalignment takes precedence over range.
  always_comb begin
    acc_err_s = 2'b00;
    if ((lsu_size_i == 2'b11) ||
        (lsu_size_i == 2'b01 && lsu_addr_i[0]) ||
        (lsu_size_i == 2'b10 && lsu_addr_i[1:0] != 2'b00)) begin
      acc_err_s = 2'b01;
    end else if (({1'b0, lsu_addr_i} < {1'b0, DMEM_BASE}) || ({1'b0, lsu_addr_i} >= win_end_s)) begin
      acc_err_s = 2'b10;
    end else begin
      acc_err_s = 2'b00;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic; ack outside RD/WR is ignored.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!lsu_req_i)                                state_s = IDLE;
        else if (acc_err_s != 2'b00)                   state_s = RESP;
        else if (lsu_we_i && lsu_size_i == 2'b10)      state_s = WR;
        else                                           state_s = RD;
      end
      RD: begin
        if (dbus_i.ack)      state_s = we_r ? WR : RESP;
        else if (timeout_s)  state_s = RESP;
        else                 state_s = RD;
      end
      WR: begin
        if (dbus_i.ack || timeout_s) state_s = RESP;
        else                         state_s = WR;
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Access context, write word, response data and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r    <= 32'h0000_0000;
      wdata_r   <= 32'h0000_0000;
      wr_word_r <= 32'h0000_0000;
      rdata_r   <= 32'h0000_0000;
      size_r    <= 2'b00;
      err_r     <= 2'b00;
      we_r      <= 1'b0;
      uns_r     <= 1'b0;
      cnt_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (lsu_req_i) begin
            addr_r    <= lsu_addr_i;
            wdata_r   <= lsu_wdata_i;
            wr_word_r <= lsu_wdata_i;
            size_r    <= lsu_size_i;
            we_r      <= lsu_we_i;
            uns_r     <= lsu_unsigned_i;
            err_r     <= acc_err_s;
            rdata_r   <= 32'h0000_0000;
            cnt_r     <= '0;
          end
        end
        RD: begin
          if (dbus_i.ack) begin
            cnt_r <= '0;
            if (we_r) wr_word_r <= merge_store(dbus_i.r_data, wdata_r, size_r, addr_r[1:0]);
            else      rdata_r   <= extract_load(dbus_i.r_data, size_r, addr_r[1:0], uns_r);
          end else if (timeout_s) begin
            err_r <= 2'b11;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        WR: begin
          if (dbus_i.ack)     cnt_r <= '0;
          else if (timeout_s) err_r <= 2'b11;
          else                cnt_r <= cnt_r + CNT_W'(1);
        end
        default: cnt_r <= '0;
      endcase
    end
  end

  // Bus outputs decode from the registered state so they drop on the edge after ack.
  always_comb begin
    dbus_o        = '0;
    dbus_o.req    = (state_r == RD) || (state_r == WR);
    dbus_o.w_en   = (state_r == WR);
    if (dbus_o.req) dbus_o.addr = (addr_r - DMEM_BASE) >> 2;
    else            dbus_o.addr = 32'h0000_0000;
    if (dbus_o.w_en) dbus_o.w_data = wr_word_r;
    else             dbus_o.w_data = 32'h0000_0000;
  end

  assign dmem_sel_o  = dbus_o.req;
  assign lsu_busy_o  = (state_r != IDLE);
  assign lsu_done_o  = (state_r == RESP);
  assign lsu_err_o   = err_r;
  assign lsu_rdata_o = rdata_r;

endmodule

// File: tb/tb_dbus_lsu_master.sv
// Randomized bench for dbus_lsu_master: a memory responder plus an arithmetic
// reference model of the load/store rules, latency and bus-activity counts.
module tb_dbus_lsu_master;
  import dbus_lsu_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] BYTES = 32'h0001_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            lsu_req_i = 1'b0, lsu_we_i = 1'b0, lsu_unsigned_i = 1'b0;
  logic [1:0]      lsu_size_i = 2'b00;
  logic [31:0]     lsu_addr_i = 32'h0, lsu_wdata_i = 32'h0;
  logic            lsu_busy_o, lsu_done_o, dmem_sel_o;
  logic [1:0]      lsu_err_o;
  logic [31:0]     lsu_rdata_o;
  type_dbus2peri_s dbus_o;
  type_peri2dbus_s peri;

  logic        ack_en = 1'b1;
  logic        init_mem = 1'b1;
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = 6'd0;
  logic [31:0] poke_val = 32'h0;
  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];
  int          wr_count = 0;
  int          checks = 0;
  int          errors = 0;

  dbus_lsu_master #(.DMEM_BASE(BASE), .DMEM_BYTES(BYTES), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i),
    .lsu_size_i(lsu_size_i), .lsu_unsigned_i(lsu_unsigned_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_busy_o(lsu_busy_o), .lsu_done_o(lsu_done_o),
    .lsu_err_o(lsu_err_o), .lsu_rdata_o(lsu_rdata_o), .dmem_sel_o(dmem_sel_o),
    .dbus_o(dbus_o), .dbus_i(peri)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int i);
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: acks one cycle after sampling req, single-cycle ack.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed_word(i);
      peri <= '0;
    end else if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end else if (peri.ack) begin
      peri.ack <= 1'b0;
    end else if (dbus_o.req && ack_en) begin
      peri.ack    <= 1'b1;
      peri.r_data <= mem[dbus_o.addr[5:0]];
      if (dbus_o.w_en) begin
        mem[dbus_o.addr[5:0]] <= dbus_o.w_data;
        wr_count <= wr_count + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_idx = idx[5:0]; poke_val = val; poke_en = 1'b1; ref_mem[idx] = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Drive one access, predict its outcome from the rules and compare.
  task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input string tag, output logic [31:0] got_rdata, output logic [1:0] got_err);
    logic [31:0] exp_rdata, word, v, newword;
    logic [1:0]  exp_err;
    int exp_lat, exp_req, exp_wr, lat, reqc, wc0, sel_bad, addr_bad, shift, idx;
    exp_rdata = 32'h0; exp_err = 2'b00; word = 32'h0; idx = 0;
    if (size == 2'd3 || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0)) exp_err = 2'b01;
    else if (addr < BASE || {1'b0, addr} >= {1'b0, BASE} + {1'b0, BYTES}) exp_err = 2'b10;
    else if (!ack_en) exp_err = 2'b11;
    if (exp_err == 2'b00 || exp_err == 2'b11) begin
      idx  = int'((addr - BASE) / 4);
      word = ref_mem[idx];
    end
    if (exp_err == 2'b01 || exp_err == 2'b10) begin exp_lat = 1; exp_req = 0; end
    else if (exp_err == 2'b11) begin exp_lat = 17; exp_req = 16; end
    else if (we && size != 2'd2) begin exp_lat = 5; exp_req = 4; end
    else begin exp_lat = 3; exp_req = 2; end
    exp_wr = (we && exp_err == 2'b00) ? 1 : 0;
    if (!we && exp_err == 2'b00) begin
      if (size == 2'd0) begin
        shift = (addr % 4) * 8;
        v = (word >> shift) & 32'hFF;
        if (!uns && v >= 32'd128) v = v - 32'd256;
      end else if (size == 2'd1) begin
        shift = ((addr % 4) / 2) * 16;
        v = (word >> shift) & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v - 32'd65536;
      end else v = word;
      exp_rdata = v;
    end
    if (exp_wr == 1) begin
      if (size == 2'd0) begin
        shift = (addr % 4) * 8;
        newword = (word & ~(32'hFF << shift)) | ((wdata & 32'hFF) << shift);
      end else if (size == 2'd1) begin
        shift = ((addr % 4) / 2) * 16;
        newword = (word & ~(32'hFFFF << shift)) | ((wdata & 32'hFFFF) << shift);
      end else newword = wdata;
      ref_mem[idx] = newword;
    end

    wc0 = wr_count;
    @(negedge clk);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size; lsu_unsigned_i = uns;
    lsu_addr_i = addr; lsu_wdata_i = wdata;
    @(negedge clk);
    lsu_req_i = 1'b0;
    lat = 0; reqc = 0; sel_bad = 0; addr_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      if (dbus_o.req) begin
        reqc++;
        if (dbus_o.addr !== idx) addr_bad++;
      end
      if (dmem_sel_o !== dbus_o.req || lsu_busy_o !== 1'b1) sel_bad++;
      if (lsu_done_o) begin lat = k; break; end
      @(negedge clk);
    end
    got_rdata = lsu_rdata_o;
    got_err   = lsu_err_o;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_err"}, {30'd0, got_err}, {30'd0, exp_err});
    check({tag, "_rdata"}, got_rdata, exp_rdata);
    check({tag, "_req_cycles"}, reqc, exp_req);
    check({tag, "_writes"}, wr_count - wc0, exp_wr);
    check({tag, "_bus_addr_sel_busy"}, addr_bad + sel_bad, 0);
    if (exp_err == 2'b00 || exp_err == 2'b11) check({tag, "_mem"}, mem[idx], ref_mem[idx]);
    @(negedge clk);
    check({tag, "_idle_after"}, {31'd0, lsu_busy_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  er;
    logic [31:0] a;
    int done_seen;
    for (int i = 0; i < 64; i++) ref_mem[i] = seed_word(i);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, lsu_busy_o}, 32'd0);
    check("reset_done", {31'd0, lsu_done_o}, 32'd0);
    check("reset_sel", {31'd0, dmem_sel_o}, 32'd0);
    check("reset_err", {30'd0, lsu_err_o}, 32'd0);
    check("reset_rdata", lsu_rdata_o, 32'd0);
    check("reset_dbus", {31'd0, (dbus_o !== '0)}, 32'd0);
    @(negedge clk);
    rst = 1'b0; init_mem = 1'b0;

    poke(4, 32'h8000_00F0);
    run_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "tp_word_load", rd, er);
    check("tp_word_load_value", rd, 32'h8000_00F0);
    poke(4, 32'hF012_3456);
    run_access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, "tp_byte_signed", rd, er);
    check("tp_byte_signed_value", rd, 32'hFFFF_FFF0);
    run_access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "tp_byte_unsigned", rd, er);
    check("tp_byte_unsigned_value", rd, 32'h0000_00F0);
    poke(4, 32'h1122_3344);
    run_access(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB, "tp_byte_store", rd, er);
    check("tp_byte_store_mem", mem[4], 32'h1122_AB44);
    run_access(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, "tp_misaligned", rd, er);
    check("tp_misaligned_code", {30'd0, er}, 32'd1);
    run_access(1'b0, 2'd2, 1'b0, BASE + BYTES, 32'h0, "tp_out_of_range", rd, er);
    check("tp_out_of_range_code", {30'd0, er}, 32'd2);
    ack_en = 1'b0;
    run_access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, "tp_timeout", rd, er);
    check("tp_timeout_code", {30'd0, er}, 32'd3);

    // Reset while in RD: idle and req low after the reset edge, no done pulse.
    @(negedge clk);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'd2; lsu_addr_i = 32'h24;
    @(negedge clk);
    lsu_req_i = 1'b0;
    check("rst_mid_in_rd", {31'd0, dbus_o.req}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_busy", {31'd0, lsu_busy_o}, 32'd0);
    check("rst_mid_req", {31'd0, dbus_o.req}, 32'd0);
    @(negedge clk);
    rst = 1'b0; ack_en = 1'b1;
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (lsu_done_o) done_seen++;
    end
    check("rst_mid_no_done", done_seen, 0);

    for (int n = 0; n < 80; n++) begin
      ack_en = ($urandom_range(0, 11) != 0);
      case ($urandom_range(0, 9))
        0:       a = BYTES + BASE + $urandom_range(0, 255);
        1:       a = $urandom;
        default: a = BASE + $urandom_range(0, 255);
      endcase
      run_access($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                 a, $urandom, $sformatf("rand%0d", n), rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
